// File: rtl/sync_pkg.sv
// Shared helpers for the bit synchroniser family: counter sizing and parameter legality.
package sync_pkg;

  localparam int unsigned MIN_BUS_WIDTH  = 1;
  localparam int unsigned MIN_STAGES     = 2;
  localparam int unsigned MIN_FILTER_CNT = 1;

  // Counter width for a filter of n samples; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // True when the channel count, chain depth and filter length are all legal.
  function automatic bit params_ok(input int unsigned bus_width,
                                   input int unsigned num_stages,
                                   input int unsigned filter_cnt);
    return (bus_width >= MIN_BUS_WIDTH) && (num_stages >= MIN_STAGES) &&
           (filter_cnt >= MIN_FILTER_CNT);
  endfunction

endpackage

// File: rtl/glitch_filter.sv
// One channel of glitch filtering: SYNC follows s only after FILTER_CNT consecutive
// differing samples, with registered one-cycle rise/fall pulses.
//   clk, rst_n : clock, async active-low reset
//   s          : synchronised (chain output) level
//   sync       : filtered level
//   rise, fall : registered edge pulses of sync
//   pulse_c    : combinational next-cycle rise|fall, for the shared CHANGED flop
module glitch_filter
  import sync_pkg::*;
#(
  parameter int unsigned FILTER_CNT = 4,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic sync,
  output logic rise,
  output logic fall,
  output logic pulse_c
);

  localparam int unsigned CW       = cnt_width(FILTER_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          sync_nxt;
  logic          rise_nxt;
  logic          fall_nxt;

  // Next-state: any agreeing sample restarts the count.
  always_comb begin
    cnt_nxt  = '0;
    sync_nxt = sync;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (s != sync) begin
      if (cnt == CNT_LAST) begin
        sync_nxt = s;
        rise_nxt = s;
        fall_nxt = ~s;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  assign pulse_c = rise_nxt | fall_nxt;

  // Filter state and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sync <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      sync <= sync_nxt;
      rise <= rise_nxt;
      fall <= fall_nxt;
    end
  end

endmodule

// File: rtl/bit_sync_filt.sv
// Multi-channel bit synchroniser with per-channel glitch filter and edge pulses.
// Only for independent control/status bits; channels have no mutual coherency.
//   CLK, RST_n : destination clock, async active-low reset
//   ASYNC      : asynchronous inputs, one per channel
//   SYNC       : synchronised, filtered levels
//   RISE, FALL : one-cycle pulses on SYNC 0->1 / 1->0
//   CHANGED    : registered OR of all RISE|FALL
module bit_sync_filt
  import sync_pkg::*;
#(
  parameter int unsigned          BUS_WIDTH  = 1,
  parameter int unsigned          NUM_STAGES = 2,
  parameter int unsigned          FILTER_CNT = 4,
  parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic                 CHANGED
);

  // Reject illegal configurations at elaboration.
  if (!params_ok(BUS_WIDTH, NUM_STAGES, FILTER_CNT)) begin : g_param_err
    $error("bit_sync_filt: need BUS_WIDTH>=1, NUM_STAGES>=2, FILTER_CNT>=1");
  end

  logic [BUS_WIDTH-1:0] chain [NUM_STAGES];
  logic [BUS_WIDTH-1:0] pulse;

  // Synchroniser flop chain; the last stage feeds the filters.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        chain[k] <= RST_VAL;
      end
    end else begin
      chain[0] <= ASYNC;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        chain[k] <= chain[k-1];
      end
    end
  end

  // One independent filter per channel.
  for (genvar ch = 0; ch < BUS_WIDTH; ch++) begin : g_chan
    glitch_filter #(
      .FILTER_CNT(FILTER_CNT),
      .RST_VAL   (RST_VAL[ch])
    ) u_filt (
      .clk    (CLK),
      .rst_n  (RST_n),
      .s      (chain[NUM_STAGES-1][ch]),
      .sync   (SYNC[ch]),
      .rise   (RISE[ch]),
      .fall   (FALL[ch]),
      .pulse_c(pulse[ch])
    );
  end

  // CHANGED is registered from the same next-pulse terms, so it aligns with RISE/FALL.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      CHANGED <= 1'b0;
    end else begin
      CHANGED <= |pulse;
    end
  end

endmodule
